// File: rtl/tf_rom_streamer.sv
// tf_rom_streamer
//   Sequencer and stream adapter in front of the twiddle-factor ROM of the
//   radix-2 8-BFU NTT core.
//   - LOAD job: accepts a valid/ready stream of packed twiddle words and writes
//     them into consecutive ROM addresses.
//   - READ job: reads a block of consecutive ROM words and delivers them on a
//     valid/ready stream. A 2-entry skid FIFO hides the 1-cycle ROM latency.
//   Addresses wrap modulo depth_rom.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   start, mode           job request (mode 0 = READ, 1 = LOAD), sampled in IDLE
//   base, len             first address and word count of the job
//   in_valid/in_ready/in_data     LOAD input stream
//   out_valid/out_ready/out_data  READ output stream (out_data = FIFO head)
//   busy, done            job in progress / one-cycle completion pulse
//   rom_A/rom_D/rom_EN/rom_REN    ROM port pins (REN 1 = read, 0 = write)
//   rom_Q                 ROM registered read data, valid the cycle after a read
//
// Handshake rule for both streams: a word moves on a rising edge where valid
// and ready are both high. valid never depends on ready; once raised, out_valid
// and out_data hold until the word is taken.

module tf_rom_streamer #(
    parameter int addr_rom_width = 9,
    parameter int data_width     = 112,
    parameter int depth_rom      = 319
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      mode,
    input  logic [addr_rom_width-1:0] base,
    input  logic [addr_rom_width-1:0] len,
    input  logic                      in_valid,
    input  logic [data_width-1:0]     in_data,
    output logic                      in_ready,
    output logic                      out_valid,
    output logic [data_width-1:0]     out_data,
    input  logic                      out_ready,
    output logic                      busy,
    output logic                      done,
    output logic [addr_rom_width-1:0] rom_A,
    output logic [data_width-1:0]     rom_D,
    output logic                      rom_EN,
    output logic                      rom_REN,
    input  logic [data_width-1:0]     rom_Q
);

    localparam int AW   = addr_rom_width;
    localparam int DW   = data_width;
    localparam int AWP1 = addr_rom_width + 1;
    localparam logic [AW:0] DEPTH_EXT = AWP1'(depth_rom);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_READ  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] base_q, base_d;
    logic [AW-1:0] len_q, len_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          inflight_q, inflight_d;
    logic          done_q, done_d;
    logic [DW-1:0] fifo_mem_q [2];
    logic [DW-1:0] fifo_mem_d [2];
    logic          wr_ptr_q, wr_ptr_d;
    logic          rd_ptr_q, rd_ptr_d;
    logic [1:0]    fifo_cnt_q, fifo_cnt_d;

    logic [AW:0]   addr_sum;
    logic [AW:0]   addr_wrap;
    logic [2:0]    occ_next;
    logic          pop;
    logic          push;
    logic          issue;
    logic          wr;
    logic          last_idx;

    // base < depth and idx < depth, so a single conditional subtract wraps.
    assign addr_sum  = {1'b0, base_q} + {1'b0, idx_q};
    assign addr_wrap = (addr_sum >= DEPTH_EXT) ? (addr_sum - DEPTH_EXT) : addr_sum;
    assign last_idx  = (idx_q == (len_q - AW'(1)));

    assign out_valid = (fifo_cnt_q != 2'd0);
    assign out_data  = fifo_mem_q[rd_ptr_q];
    assign pop       = out_valid & out_ready;
    assign push      = inflight_q;

    // Words that will be held once this cycle's pop is taken into account:
    // FIFO contents plus the read returning now. Issuing keeps it <= 2, so
    // the FIFO can never overflow.
    assign occ_next = {1'b0, fifo_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue    = (state_q == ST_READ) && (occ_next < 3'd2);
    assign wr       = (state_q == ST_LOAD) && in_valid;

    assign in_ready = (state_q == ST_LOAD);
    assign busy     = (state_q != ST_IDLE) || done_q;
    assign done     = done_q;
    assign rom_EN   = wr || issue;
    assign rom_REN  = !wr;
    assign rom_A    = ((state_q == ST_LOAD) || (state_q == ST_READ)) ? addr_wrap[AW-1:0] : '0;
    assign rom_D    = wr ? in_data : '0;

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        len_d      = len_q;
        idx_d      = idx_q;
        done_d     = 1'b0;
        inflight_d = issue;
        fifo_mem_d = fifo_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q + {1'b0, push} - {1'b0, pop};

        if (push) begin
            fifo_mem_d[wr_ptr_q] = rom_Q;
            wr_ptr_d             = !wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = !rd_ptr_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        base_d  = base;
                        len_d   = len;
                        idx_d   = '0;
                        state_d = mode ? ST_LOAD : ST_READ;
                    end
                end
            end
            ST_LOAD: begin
                if (wr) begin
                    idx_d = idx_q + AW'(1);
                    if (last_idx) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_READ: begin
                if (issue) begin
                    idx_d = idx_q + AW'(1);
                    if (last_idx) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            default: begin
                // Last word leaves when the FIFO holds one word, nothing is in
                // flight and the consumer takes it.
                if (pop && (fifo_cnt_q == 2'd1) && !inflight_q) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            base_q        <= '0;
            len_q         <= '0;
            idx_q         <= '0;
            inflight_q    <= 1'b0;
            done_q        <= 1'b0;
            fifo_mem_q[0] <= '0;
            fifo_mem_q[1] <= '0;
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
            fifo_cnt_q    <= 2'd0;
        end else begin
            state_q       <= state_d;
            base_q        <= base_d;
            len_q         <= len_d;
            idx_q         <= idx_d;
            inflight_q    <= inflight_d;
            done_q        <= done_d;
            fifo_mem_q[0] <= fifo_mem_d[0];
            fifo_mem_q[1] <= fifo_mem_d[1];
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            fifo_cnt_q    <= fifo_cnt_d;
        end
    end

endmodule
